// File: rtl/mem_lsu_if.sv
// Bus bundle for the MEM-stage load/store unit: pipeline request side,
// stall/writeback outputs and the word-organised data-memory port.
interface mem_lsu_if #(
  parameter int DATA_W = 32,
  parameter int DM_AW  = 10
);
  logic              req_valid;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [31:0]       req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [4:0]        req_rd;

  logic              stall;

  logic              DM_read;
  logic              DM_write;
  logic [DM_AW-1:0]  DM_addr;
  logic [DATA_W-1:0] DM_in;
  logic [DATA_W-1:0] DM_out;

  logic              wb_valid;
  logic [4:0]        wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              misalign;

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, req_rd,
    input  DM_out,
    output stall, DM_read, DM_write, DM_addr, DM_in,
    output wb_valid, wb_rd, wb_data, misalign
  );

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, req_rd,
    output DM_out,
    input  stall, DM_read, DM_write, DM_addr, DM_in,
    input  wb_valid, wb_rd, wb_data, misalign
  );
endinterface

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: sized byte-addressed requests to word DM accesses,
// sub-word stores as a 2-cycle read-modify-write, registered extended load data.
module mem_lsu #(
  parameter int DATA_W = 32,
  parameter int DM_AW  = 10
) (
  input  logic     clk,
  input  logic     rst,
  mem_lsu_if.slave bus
);

  typedef enum logic {IDLE, RMW_WR} state_t;

  state_t            state_q, state_d;
  logic              wb_valid_q, wb_valid_d;
  logic [4:0]        wb_rd_q, wb_rd_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              misalign_q, misalign_d;
  logic [DM_AW-1:0]  rmw_addr_q, rmw_addr_d;
  logic [DATA_W-1:0] rmw_data_q, rmw_data_d;

  logic              stall;
  logic              dm_read;
  logic              dm_write;
  logic [DM_AW-1:0]  dm_addr;
  logic [DATA_W-1:0] dm_in;

  logic [DM_AW-1:0]  word_addr;
  logic              aligned;
  logic [7:0]        byte_val;
  logic [15:0]       half_val;
  logic [DATA_W-1:0] load_val;
  logic [DATA_W-1:0] merged;
  logic              unused_addr_bits;

  assign word_addr        = bus.req_addr[DM_AW+1:2];
  assign unused_addr_bits = ^bus.req_addr[31:DM_AW+2];

  always_comb begin
    aligned = 1'b0;
    case (bus.req_size)
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~bus.req_addr[0];
      2'b10:   aligned = (bus.req_addr[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
  end

  // Lane extraction for loads and lane replacement for sub-word stores share the DM read data.
  always_comb begin
    byte_val = bus.DM_out[{bus.req_addr[1:0], 3'b000} +: 8];
    half_val = bus.DM_out[{bus.req_addr[1], 4'b0000} +: 16];
    load_val = bus.DM_out;
    if (bus.req_size == 2'b00) begin
      load_val = {{(DATA_W-8){byte_val[7] & bus.req_signed}}, byte_val};
    end else if (bus.req_size == 2'b01) begin
      load_val = {{(DATA_W-16){half_val[15] & bus.req_signed}}, half_val};
    end
    merged = bus.DM_out;
    if (bus.req_size == 2'b00) begin
      merged[{bus.req_addr[1:0], 3'b000} +: 8] = bus.req_wdata[7:0];
    end else begin
      merged[{bus.req_addr[1], 4'b0000} +: 16] = bus.req_wdata[15:0];
    end
  end

  always_comb begin
    state_d    = state_q;
    wb_valid_d = 1'b0;
    wb_rd_d    = '0;
    wb_data_d  = '0;
    misalign_d = 1'b0;
    rmw_addr_d = rmw_addr_q;
    rmw_data_d = rmw_data_q;
    stall      = 1'b0;
    dm_read    = 1'b0;
    dm_write   = 1'b0;
    dm_addr    = '0;
    dm_in      = '0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            if (!aligned) begin
              misalign_d = 1'b1;
            end else if (!bus.req_write) begin
              dm_read    = 1'b1;
              dm_addr    = word_addr;
              wb_valid_d = 1'b1;
              wb_rd_d    = bus.req_rd;
              wb_data_d  = load_val;
            end else if (bus.req_size == 2'b10) begin
              dm_write = 1'b1;
              dm_addr  = word_addr;
              dm_in    = bus.req_wdata;
            end else begin
              dm_read    = 1'b1;
              dm_addr    = word_addr;
              stall      = 1'b1;
              rmw_addr_d = word_addr;
              rmw_data_d = merged;
              state_d    = RMW_WR;
            end
          end
        end
        RMW_WR: begin
          // The upstream store is still presented here and must not be re-executed.
          dm_write = 1'b1;
          dm_addr  = rmw_addr_q;
          dm_in    = rmw_data_q;
          state_d  = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      misalign_q <= 1'b0;
      rmw_addr_q <= '0;
      rmw_data_q <= '0;
    end else begin
      state_q    <= state_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      misalign_q <= misalign_d;
      rmw_addr_q <= rmw_addr_d;
      rmw_data_q <= rmw_data_d;
    end
  end

  assign bus.stall    = stall;
  assign bus.DM_read  = dm_read;
  assign bus.DM_write = dm_write;
  assign bus.DM_addr  = dm_addr;
  assign bus.DM_in    = dm_in;
  assign bus.wb_valid = wb_valid_q;
  assign bus.wb_rd    = wb_rd_q;
  assign bus.wb_data  = wb_data_q;
  assign bus.misalign = misalign_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: byte-level reference memory plus a queue of
// expected writeback/misalign results, one entry per clock cycle.
module tb_mem_lsu;
  localparam int DATA_W = 32;
  localparam int DM_AW  = 10;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        mis;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   testsRun = 0;
  int   testsFailed = 0;
  int   writeCount = 0;
  logic [31:0] lastWbData;
  logic [31:0] lastDmIn;
  exp_t sbQ[$];

  logic [31:0] dm [0:(1<<DM_AW)-1];
  logic [7:0]  refMem [0:(4<<DM_AW)-1];

  always #5 clk = ~clk;

  mem_lsu_if #(.DATA_W(DATA_W), .DM_AW(DM_AW)) bus();

  mem_lsu #(.DATA_W(DATA_W), .DM_AW(DM_AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Data memory: combinational read, write at the clock edge.
  assign bus.DM_out = dm[bus.DM_addr];

  always @(posedge clk) begin
    if (bus.DM_write) begin
      dm[bus.DM_addr] <= bus.DM_in;
      writeCount      <= writeCount + 1;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    if (obs !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] refWord(input logic [31:0] a);
    int i;
    i = int'({a[DM_AW+1:2], 2'b00});
    return {refMem[i+3], refMem[i+2], refMem[i+1], refMem[i]};
  endfunction

  function automatic logic [31:0] refLoad(input logic [1:0] size, input logic sgn, input logic [31:0] a);
    int i;
    logic [7:0]  b;
    logic [15:0] h;
    i = int'(a[DM_AW+1:0]);
    b = refMem[i];
    h = {refMem[i+1], refMem[i]};
    if (size == 2'b00) return {{24{b[7] & sgn}}, b};
    if (size == 2'b01) return {{16{h[15] & sgn}}, h};
    return refWord(a);
  endfunction

  task automatic refStore(input logic [1:0] size, input logic [31:0] a, input logic [31:0] wd);
    int i;
    i = int'(a[DM_AW+1:0]);
    refMem[i] = wd[7:0];
    if (size != 2'b00) refMem[i+1] = wd[15:8];
    if (size == 2'b10) begin
      refMem[i+2] = wd[23:16];
      refMem[i+3] = wd[31:24];
    end
  endtask

  task automatic pushExp(input logic valid, input logic [4:0] rd, input logic [31:0] data, input logic mis);
    exp_t e;
    e.valid = valid;
    e.rd    = rd;
    e.data  = data;
    e.mis   = mis;
    sbQ.push_back(e);
  endtask

  // Advance one edge and compare the registered outputs with the oldest expectation.
  task automatic stepCycle();
    exp_t e;
    @(posedge clk);
    #1;
    lastWbData = bus.wb_data;
    if (sbQ.size() == 0) begin
      checkOutput("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sbQ.pop_front();
      checkOutput("wb_valid", {31'b0, bus.wb_valid}, {31'b0, e.valid});
      checkOutput("misalign", {31'b0, bus.misalign}, {31'b0, e.mis});
      if (e.valid) begin
        checkOutput("wb_rd", {27'b0, bus.wb_rd}, {27'b0, e.rd});
        checkOutput("wb_data", bus.wb_data, e.data);
      end
    end
  endtask

  task automatic checkBusIdle(input string tag);
    checkOutput({tag, "_stall"}, {31'b0, bus.stall}, 32'd0);
    checkOutput({tag, "_rd"}, {31'b0, bus.DM_read}, 32'd0);
    checkOutput({tag, "_wr"}, {31'b0, bus.DM_write}, 32'd0);
    checkOutput({tag, "_addr"}, 32'(bus.DM_addr), 32'd0);
    checkOutput({tag, "_in"}, bus.DM_in, 32'd0);
  endtask

  task automatic idleCycle();
    bus.req_valid = 1'b0;
    #1;
    checkBusIdle("idle");
    pushExp(1'b0, 5'd0, 32'd0, 1'b0);
    stepCycle();
  endtask

  task automatic applyStimulus(input logic write, input logic [1:0] size, input logic sgn,
                               input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd);
    logic ok;
    ok = (size == 2'b00) || (size == 2'b01 && !addr[0]) || (size == 2'b10 && addr[1:0] == 2'b00);
    bus.req_valid  = 1'b1;
    bus.req_write  = write;
    bus.req_size   = size;
    bus.req_signed = sgn;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    bus.req_rd     = rd;
    #1;
    checkOutput("rd_wr_excl", {31'b0, bus.DM_read & bus.DM_write}, 32'd0);
    if (!ok) begin
      checkOutput("bad_stall", {31'b0, bus.stall}, 32'd0);
      checkOutput("bad_rd", {31'b0, bus.DM_read}, 32'd0);
      checkOutput("bad_wr", {31'b0, bus.DM_write}, 32'd0);
      pushExp(1'b0, 5'd0, 32'd0, 1'b1);
    end else if (!write) begin
      checkOutput("ld_rd", {31'b0, bus.DM_read}, 32'd1);
      checkOutput("ld_wr", {31'b0, bus.DM_write}, 32'd0);
      checkOutput("ld_stall", {31'b0, bus.stall}, 32'd0);
      checkOutput("ld_addr", 32'(bus.DM_addr), 32'(addr[DM_AW+1:2]));
      pushExp(1'b1, rd, refLoad(size, sgn, addr), 1'b0);
    end else if (size == 2'b10) begin
      checkOutput("sw_wr", {31'b0, bus.DM_write}, 32'd1);
      checkOutput("sw_rd", {31'b0, bus.DM_read}, 32'd0);
      checkOutput("sw_stall", {31'b0, bus.stall}, 32'd0);
      checkOutput("sw_addr", 32'(bus.DM_addr), 32'(addr[DM_AW+1:2]));
      checkOutput("sw_in", bus.DM_in, wdata);
      lastDmIn = bus.DM_in;
      refStore(size, addr, wdata);
      pushExp(1'b0, 5'd0, 32'd0, 1'b0);
    end else begin
      checkOutput("rmw_rd", {31'b0, bus.DM_read}, 32'd1);
      checkOutput("rmw_wr", {31'b0, bus.DM_write}, 32'd0);
      checkOutput("rmw_stall", {31'b0, bus.stall}, 32'd1);
      checkOutput("rmw_addr", 32'(bus.DM_addr), 32'(addr[DM_AW+1:2]));
      pushExp(1'b0, 5'd0, 32'd0, 1'b0);
      stepCycle();
      refStore(size, addr, wdata);
      checkOutput("rmw2_wr", {31'b0, bus.DM_write}, 32'd1);
      checkOutput("rmw2_rd", {31'b0, bus.DM_read}, 32'd0);
      checkOutput("rmw2_stall", {31'b0, bus.stall}, 32'd0);
      checkOutput("rmw2_addr", 32'(bus.DM_addr), 32'(addr[DM_AW+1:2]));
      checkOutput("rmw2_in", bus.DM_in, refWord(addr));
      lastDmIn = bus.DM_in;
      pushExp(1'b0, 5'd0, 32'd0, 1'b0);
    end
    stepCycle();
    bus.req_valid = 1'b0;
  endtask

  initial begin
    int wc;
    for (int i = 0; i < (1<<DM_AW); i++) dm[i] = 32'd0;
    for (int i = 0; i < (4<<DM_AW); i++) refMem[i] = 8'd0;
    rst            = 1'b1;
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b0;
    bus.req_size   = 2'b10;
    bus.req_signed = 1'b0;
    bus.req_addr   = 32'h10;
    bus.req_wdata  = 32'hFFFF_FFFF;
    bus.req_rd     = 5'd7;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      checkBusIdle("reset");
      pushExp(1'b0, 5'd0, 32'd0, 1'b0);
      stepCycle();
      checkOutput("reset_wb_rd", {27'b0, bus.wb_rd}, 32'd0);
      checkOutput("reset_wb_data", bus.wb_data, 32'd0);
    end
    rst = 1'b0;
    idleCycle();

    // Word store then word load.
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 5'd0);
    checkOutput("plan_sw_addr_in", lastDmIn, 32'hDEADBEEF);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 5'd5);
    checkOutput("plan_lw", lastWbData, 32'hDEADBEEF);

    // Byte store via read-modify-write.
    applyStimulus(1'b1, 2'b00, 1'b0, 32'h12, 32'h0000_0055, 5'd0);
    checkOutput("plan_sb_merge", lastDmIn, 32'hDE55BEEF);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 5'd6);
    checkOutput("plan_lw2", lastWbData, 32'hDE55BEEF);

    // Sub-word loads with extension.
    applyStimulus(1'b0, 2'b00, 1'b1, 32'h13, 32'd0, 5'd1);
    checkOutput("plan_lb", lastWbData, 32'hFFFFFFDE);
    applyStimulus(1'b0, 2'b00, 1'b0, 32'h13, 32'd0, 5'd2);
    checkOutput("plan_lbu", lastWbData, 32'h000000DE);
    applyStimulus(1'b0, 2'b01, 1'b1, 32'h10, 32'd0, 5'd3);
    checkOutput("plan_lh", lastWbData, 32'hFFFFBEEF);
    applyStimulus(1'b0, 2'b01, 1'b0, 32'h12, 32'd0, 5'd4);
    checkOutput("plan_lhu", lastWbData, 32'h0000DE55);

    // Misaligned and illegal requests leave memory untouched.
    wc = writeCount;
    applyStimulus(1'b0, 2'b01, 1'b0, 32'h11, 32'd0, 5'd8);
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h12, 32'h1111_1111, 5'd0);
    applyStimulus(1'b1, 2'b11, 1'b0, 32'h10, 32'h2222_2222, 5'd0);
    idleCycle();
    checkOutput("mis_no_write", 32'(writeCount), 32'(wc));
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 5'd9);
    checkOutput("mis_mem_kept", lastWbData, 32'hDE55BEEF);

    // Reset during RMW_WR aborts the write.
    wc = writeCount;
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b1;
    bus.req_size   = 2'b01;
    bus.req_signed = 1'b0;
    bus.req_addr   = 32'h10;
    bus.req_wdata  = 32'h0000_1234;
    #1;
    checkOutput("abort_stall", {31'b0, bus.stall}, 32'd1);
    pushExp(1'b0, 5'd0, 32'd0, 1'b0);
    stepCycle();
    rst = 1'b1;
    #1;
    checkBusIdle("abort");
    pushExp(1'b0, 5'd0, 32'd0, 1'b0);
    stepCycle();
    rst = 1'b0;
    idleCycle();
    checkOutput("abort_no_write", 32'(writeCount), 32'(wc));
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 5'd10);
    checkOutput("abort_mem_kept", lastWbData, 32'hDE55BEEF);

    // Byte store immediately followed by a load of the same byte.
    wc = writeCount;
    applyStimulus(1'b1, 2'b00, 1'b0, 32'h20, 32'h0000_00A5, 5'd0);
    applyStimulus(1'b0, 2'b00, 1'b0, 32'h20, 32'd0, 5'd11);
    checkOutput("b2b_load", lastWbData, 32'h000000A5);
    checkOutput("b2b_one_write", 32'(writeCount), 32'(wc + 1));

    // Mixed random traffic against the reference memory.
    for (int n = 0; n < 40; n++) begin
      applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    32'($urandom_range(0, 63)), $urandom, 5'($urandom_range(0, 31)));
      if ($urandom_range(0, 3) == 0) idleCycle();
    end
    idleCycle();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
